// File: rtl/model_pkg.sv
// Shared constants, entry packing and FSM state encoding for model_loader.
package model_pkg;

  localparam logic [7:0] SYNC       = 8'hA5;
  localparam logic [7:0] TYPE_INDEX = 8'h01;
  localparam logic [7:0] TYPE_POS   = 8'h02;
  localparam logic [7:0] TYPE_NORM  = 8'h03;

  localparam logic [3:0] LEN_INDEX = 4'd5;
  localparam logic [3:0] LEN_VEC   = 4'd12;

  localparam int W_INDEX = 36;
  localparam int W_VEC   = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    K_INDEX,
    K_POS,
    K_NORM
  } kind_t;

  // Index entries keep only the low 36 bits of the 40 shifted in.
  function automatic logic [W_VEC-1:0] pack_entry(
    input kind_t             k,
    input logic [W_VEC-1:0]  s
  );
    if (k == K_INDEX)
      return {{(W_VEC-W_INDEX){1'b0}}, s[W_INDEX-1:0]};
    return s;
  endfunction

endpackage

// File: rtl/model_loader.sv
// UART packet parser that writes index/position/normal memory entries.
// Define MODEL_LOADER_CHECKSUM_EN to require a trailing XOR CHECK byte.
module model_loader
  import model_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic        wr_index_en_out,
  output logic        wr_position_en_out,
  output logic        wr_normal_en_out,
  output logic [11:0] wr_addr_out,
  output logic [95:0] wr_data_out,
  output logic        busy_out,
  output logic        error_out,
  output logic [15:0] write_count_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  kind_t       kind;
  logic [11:0] addr;
  logic [95:0] shreg;
  logic [95:0] shnext;
  logic [3:0]  cnt;
  logic [TW-1:0] tmo;

  logic        commit;
  logic        drop;
  logic [95:0] commit_src;

  assign shnext   = {shreg[87:0], byte_in};
  assign busy_out = (state != S_IDLE);

`ifdef MODEL_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      csum <= '0;
    else if (byte_valid_in)
      csum <= (state == S_TYPE) ? byte_in : csum ^ byte_in;
  end

  always_comb begin
    commit     = 1'b0;
    drop       = 1'b0;
    commit_src = shreg;
    if (byte_valid_in && state == S_CHECK) begin
      commit = (byte_in == csum);
      drop   = (byte_in != csum);
    end
  end
`else
  always_comb begin
    commit     = 1'b0;
    drop       = 1'b0;
    commit_src = shnext;
    if (byte_valid_in && state == S_PAYLOAD && cnt == 4'd0)
      commit = 1'b1;
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= S_IDLE;
      kind               <= K_INDEX;
      addr               <= '0;
      shreg              <= '0;
      cnt                <= '0;
      tmo                <= '0;
      wr_index_en_out    <= 1'b0;
      wr_position_en_out <= 1'b0;
      wr_normal_en_out   <= 1'b0;
      wr_addr_out        <= '0;
      wr_data_out        <= '0;
      error_out          <= 1'b0;
      write_count_out    <= '0;
    end else begin
      wr_index_en_out    <= 1'b0;
      wr_position_en_out <= 1'b0;
      wr_normal_en_out   <= 1'b0;
      error_out          <= drop;

      if (state == S_IDLE || byte_valid_in) begin
        tmo <= '0;
      end else if (tmo == TMO_LAST) begin
        tmo       <= '0;
        state     <= S_IDLE;
        error_out <= 1'b1;
      end else begin
        tmo <= tmo + TW'(1);
      end

      if (byte_valid_in) begin
        unique case (state)
          S_IDLE: if (byte_in == SYNC) state <= S_TYPE;
          S_TYPE: begin
            unique case (1'b1)
              byte_in == TYPE_INDEX: begin
                kind  <= K_INDEX;
                state <= S_ADDR_HI;
              end
              byte_in == TYPE_POS: begin
                kind  <= K_POS;
                state <= S_ADDR_HI;
              end
              byte_in == TYPE_NORM: begin
                kind  <= K_NORM;
                state <= S_ADDR_HI;
              end
              default: begin
                error_out <= 1'b1;
                state     <= S_IDLE;
              end
            endcase
          end
          S_ADDR_HI: begin
            addr[11:8] <= byte_in[3:0];
            state      <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr[7:0] <= byte_in;
            cnt   <= (kind == K_INDEX) ? LEN_INDEX - 4'd1
                                       : LEN_VEC - 4'd1;
            state <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            shreg <= shnext;
            cnt   <= cnt - 4'd1;
`ifdef MODEL_LOADER_CHECKSUM_EN
            if (cnt == 4'd0) state <= S_CHECK;
`else
            if (cnt == 4'd0) state <= S_IDLE;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end

      if (commit) begin
        wr_index_en_out    <= (kind == K_INDEX);
        wr_position_en_out <= (kind == K_POS);
        wr_normal_en_out   <= (kind == K_NORM);
        wr_addr_out        <= addr;
        wr_data_out        <= pack_entry(kind, commit_src);
        write_count_out    <= write_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_model_loader.sv
// Directed self-checking bench for model_loader (TIMEOUT_CYCLES=16).
// Sends a CHECK byte only when MODEL_LOADER_CHECKSUM_EN is defined.
module tb_model_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bv  = 1'b0;
  logic [7:0]  bd  = 8'h00;
  logic        w_idx, w_pos, w_nrm;
  logic [11:0] w_addr;
  logic [95:0] w_data;
  logic        busy, err;
  logic [15:0] wcnt;

  int checks = 0;
  int errors = 0;
  int n_idx = 0, n_pos = 0, n_nrm = 0, n_err = 0;
  int exp_err = 0;
  logic [7:0] pl [12];

  model_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .byte_valid_in      (bv),
    .byte_in            (bd),
    .wr_index_en_out    (w_idx),
    .wr_position_en_out (w_pos),
    .wr_normal_en_out   (w_nrm),
    .wr_addr_out        (w_addr),
    .wr_data_out        (w_data),
    .busy_out           (busy),
    .error_out          (err),
    .write_count_out    (wcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_idx += int'(w_idx);
    n_pos += int'(w_pos);
    n_nrm += int'(w_nrm);
    n_err += int'(err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bv = 1'b1;
    bd = b;
    @(posedge clk);
    #1;
    bv = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] t, input logic [7:0] hi,
                           input logic [7:0] lo, input int n);
    send(8'hA5);
    send(t);
    send(hi);
    send(lo);
    for (int i = 0; i < n; i++) send(pl[i]);
  endtask

`ifdef MODEL_LOADER_CHECKSUM_EN
  task automatic send_chk(input logic [7:0] t, input logic [7:0] hi,
                          input logic [7:0] lo, input int n,
                          input logic [7:0] flip);
    logic [7:0] x;
    x = t ^ hi ^ lo;
    for (int i = 0; i < n; i++) x ^= pl[i];
    send(x ^ flip);
  endtask
`endif

  task automatic send_pkt(input logic [7:0] t, input logic [7:0] hi,
                          input logic [7:0] lo, input int n);
    send_body(t, hi, lo, n);
`ifdef MODEL_LOADER_CHECKSUM_EN
    send_chk(t, hi, lo, n, 8'h00);
`endif
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_err", 96'(err), 96'd0);
    check("rst_addr", 96'(w_addr), 96'd0);
    check("rst_data", w_data, 96'd0);
    check("rst_cnt", 96'(wcnt), 96'd0);
    @(negedge clk);
    rst = 1'b0;

    // Position packet, payload 00..0B
    for (int i = 0; i < 12; i++) pl[i] = 8'(i);
    send_pkt(8'h02, 8'h01, 8'h23, 12);
    check("pos_en", 96'(w_pos), 96'd1);
    check("pos_addr", 96'(w_addr), 96'h123);
    check("pos_data", w_data, 96'h000102030405060708090A0B);
    check("pos_cnt", 96'(wcnt), 96'd1);
    check("pos_idle", 96'(busy), 96'd0);
    repeat (3) @(posedge clk);
    #1;
    check("pos_once", 96'(n_pos), 96'd1);
    check("pos_hold", w_data, 96'h000102030405060708090A0B);

    // Index packet, top nibble of first payload byte dropped
    pl[0] = 8'hFF; pl[1] = 8'h12; pl[2] = 8'h34;
    pl[3] = 8'h56; pl[4] = 8'h78;
    send_pkt(8'h01, 8'hF0, 8'h07, 5);
    check("idx_en", 96'(w_idx), 96'd1);
    check("idx_addr", 96'(w_addr), 96'h007);
    check("idx_data", w_data, 96'hF12345678);
    check("idx_cnt", 96'(wcnt), 96'd2);

    // Normal packet whose SYNC lands in the strobe cycle
    for (int i = 0; i < 12; i++) pl[i] = 8'(8'h10 + i);
    send_pkt(8'h03, 8'hFA, 8'hBC, 12);
    check("nrm_en", 96'(w_nrm), 96'd1);
    check("nrm_addr", 96'(w_addr), 96'hABC);
    check("nrm_data", w_data, 96'h101112131415161718191A1B);
    check("nrm_cnt", 96'(wcnt), 96'd3);

`ifdef MODEL_LOADER_CHECKSUM_EN
    // Bad CHECK byte
    send_body(8'h03, 8'h00, 8'h44, 12);
    send_chk(8'h03, 8'h00, 8'h44, 12, 8'h01);
    exp_err++;
    check("badchk_err", 96'(err), 96'd1);
    check("badchk_nrm", 96'(w_nrm), 96'd0);
    check("badchk_cnt", 96'(wcnt), 96'd3);
    check("badchk_addr", 96'(w_addr), 96'hABC);
`endif

    // Junk in IDLE, then bad TYPE
    send(8'h00);
    check("junk_err", 96'(err), 96'd0);
    check("junk_busy", 96'(busy), 96'd0);
    send(8'hA5);
    check("sync_busy", 96'(busy), 96'd1);
    send(8'h07);
    exp_err++;
    check("type_err", 96'(err), 96'd1);
    check("type_busy", 96'(busy), 96'd0);

    // Timeout after A5 03
    send(8'hA5);
    send(8'h03);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_early", 96'(err), 96'd0);
    check("tmo_busy", 96'(busy), 96'd1);
    @(posedge clk);
    #1;
    exp_err++;
    check("tmo_err", 96'(err), 96'd1);
    check("tmo_idle", 96'(busy), 96'd0);
    pl[0] = 8'h0A; pl[1] = 8'hBB; pl[2] = 8'hCC;
    pl[3] = 8'hDD; pl[4] = 8'hEE;
    send_pkt(8'h01, 8'h02, 8'h34, 5);
    check("tmo_idx_en", 96'(w_idx), 96'd1);
    check("tmo_idx_addr", 96'(w_addr), 96'h234);
    check("tmo_idx_data", w_data, 96'hABBCCDDEE);
    check("tmo_idx_cnt", 96'(wcnt), 96'd4);
    check("err_total", 96'(n_err), 96'(exp_err));

    // Reset after 6th byte of a position packet
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h10); send(8'h00); send(8'h11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_addr", 96'(w_addr), 96'd0);
    check("mrst_data", w_data, 96'd0);
    check("mrst_cnt", 96'(wcnt), 96'd0);
    check("mrst_busy", 96'(busy), 96'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_nowr", 96'(n_pos), 96'd1);
    check("mrst_noerr", 96'(n_err), 96'(exp_err));
    for (int i = 0; i < 12; i++) pl[i] = 8'(8'hF0 - i);
    send_pkt(8'h02, 8'h0F, 8'hFF, 12);
    check("post_en", 96'(w_pos), 96'd1);
    check("post_addr", 96'(w_addr), 96'hFFF);
    check("post_data", w_data, 96'hF0EFEEEDECEBEAE9E8E7E6E5);
    check("post_cnt", 96'(wcnt), 96'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
